// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level: synchronise, qualify STABLE_CYCLES agreeing samples,
// then commit the new level with a one-cycle rise/fall strobe and count aborted qualifications.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_in,
  output logic       clean_out,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [1:0]             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   do_rise, do_fall, do_abort;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser stage: only the last flop is trusted by the FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], raw_in};
  end

  // A revert is checked before the terminal count, so it wins on the would-be commit edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_rise   = 1'b0;
    do_fall   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      IDLE_LO: if (s) begin
        state_nxt = WAIT_HI;
        cnt_nxt   = CNT_ONE;
      end
      WAIT_HI: begin
        if (!s) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
          do_abort  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
          do_rise   = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      IDLE_HI: if (!s) begin
        state_nxt = WAIT_LO;
        cnt_nxt   = CNT_ONE;
      end
      WAIT_LO: begin
        if (s) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
          do_abort  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
          do_fall   = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE_LO;
      cnt        <= '0;
      clean_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rise_pulse <= do_rise;
      fall_pulse <= do_fall;
      busy       <= (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
      if (do_rise)       clean_out <= 1'b1;
      else if (do_fall)  clean_out <= 1'b0;
      if (do_abort)      bounce_cnt <= sat_inc(bounce_cnt);
    end
  end

endmodule
